// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue.
// Circular buffer of {nPC, IR} pairs. The head entry is presented to decode
// in first-word-fall-through fashion. A taken-branch flush empties the queue.
// When the queue is empty the outputs are forced to zero, which decode sees
// as a NOP.

`ifndef WORD
`define WORD 32
`endif

module fetch_queue #(
    parameter int WORD  = `WORD,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD-1:0]          in_npc,
    input  logic [WORD-1:0]          in_ir,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD-1:0]          out_npc,
    output logic [WORD-1:0]          out_ir,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [2*WORD-1:0] storage [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [2*WORD-1:0] headEntry;
    logic              pushEn;
    logic              popEn;

    // Handshake qualification; flush wins over both sides. in_ready is
    // decoded from count alone, so a pop in the same cycle cannot open a
    // slot for a push when the queue is full.
    always_comb begin
        in_ready  = (count < FULL_COUNT);
        out_valid = (count != '0);
        pushEn    = in_valid  && in_ready  && !flush;
        popEn     = out_valid && out_ready && !flush;
    end

    // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; left uncleared by reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            storage[wrPtr] <= {in_npc, in_ir};
        end
    end

    // Head presentation: zero (NOP) whenever the queue is empty.
    always_comb begin
        headEntry = storage[rdPtr];
        out_npc   = '0;
        out_ir    = '0;
        if (out_valid) begin
            out_npc = headEntry[2*WORD-1:WORD];
            out_ir  = headEntry[WORD-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model in a separate monitor.
`timescale 1ns/100ps

module tb_fetch_queue;

    localparam int WORD  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rstN = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD-1:0]   in_npc = '0;
    logic [WORD-1:0]   in_ir = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD-1:0]   out_npc;
    logic [WORD-1:0]   out_ir;
    logic              flush = 1'b0;
    logic [2:0]        count;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: accepted {npc, ir} entries in arrival order.
    logic [63:0] expQ [$];

    fetch_queue #(.WORD(WORD), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (rstN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_npc    (in_npc),
        .in_ir     (in_ir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_npc   (out_npc),
        .out_ir    (out_ir),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic cycle(input logic v, input logic [31:0] ir, input logic [31:0] npc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_ir     = ir;
        in_npc    = npc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: samples mid-cycle, compares against the model, then applies
    // the transition the coming rising edge will perform.
    initial begin
        int sz;
        logic [63:0] popped;
        forever begin
            @(negedge clk);
            #3;
            if (!rstN) begin
                expQ.delete();
                chk("rst_count", 64'(count), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_head", {out_npc, out_ir}, 64'd0);
            end else begin
                sz = expQ.size();
                chk("count", 64'(count), 64'(sz));
                chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
                chk("out_valid", 64'(out_valid), 64'(sz != 0));
                if (flush) begin
                    chk("head", {out_npc, out_ir}, (sz != 0) ? expQ[0] : 64'd0);
                    expQ.delete();
                end else begin
                    if (out_ready && sz != 0) begin
                        popped = expQ.pop_front();
                        chk("pop_data", {out_npc, out_ir}, popped);
                    end else begin
                        chk("head", {out_npc, out_ir}, (sz != 0) ? expQ[0] : 64'd0);
                    end
                    if (in_valid && sz < DEPTH) begin
                        expQ.push_back({in_npc, in_ir});
                    end
                end
            end
        end
    end

    initial begin
        #1 rstN = 1'b0;
        idle();
        idle();
        rstN = 1'b1;

        // Basic push, visible one clock later.
        cycle(1'b1, 32'h8C010004, 32'h4, 1'b0, 1'b0);
        idle();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_ir", 64'(out_ir), 64'h8C010004);
        chk("basic_npc", 64'(out_npc), 64'h4);
        chk("basic_count", 64'(count), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("empty_ir_nop", 64'(out_ir), 64'd0);

        // Fill to full, fifth push ignored, drain in order.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 32'(i * 32'h11), 32'(i * 4), 1'b0, 1'b0);
        end
        idle();
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h55, 32'h50, 1'b0, 1'b0);
        idle();
        chk("full_ignore_count", 64'(count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("drain_order", 64'(out_ir), 64'(i * 32'h11));
        end
        idle();
        chk("drained_valid", 64'(out_valid), 64'd0);

        // Full with simultaneous push and pop: pop only.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 32'hEE, 32'hEE0, 1'b1, 1'b0);
        chk("fullpp_head_pre", 64'(out_ir), 64'hA1);
        idle();
        chk("fullpp_count", 64'(count), 64'd3);
        chk("fullpp_head_post", 64'(out_ir), 64'hA2);
        for (int i = 2; i <= 4; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("fullpp_drain", 64'(out_ir), 64'hA0 + 64'(i));
        end
        idle();
        chk("fullpp_dropped", 64'(count), 64'd0);

        // Streaming wrap-around.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 32'(i), 32'(4 * i), 1'b1, 1'b0);
            if (i > 1) begin
                chk("stream_count", 64'(count), 64'd1);
                chk("stream_ir", 64'(out_ir), 64'(i - 1));
            end
        end
        idle();
        chk("stream_last", 64'(out_ir), 64'd10);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with concurrent push.
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 32'hB0 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 32'hBF, 32'h2FF, 1'b0, 1'b1);
        chk("preflush_count", 64'(count), 64'd3);
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ir", 64'(out_ir), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        idle();
        chk("flush_push_gone", 64'(count), 64'd0);

        // Asynchronous reset between edges at count=2.
        cycle(1'b1, 32'hD1, 32'h301, 1'b0, 1'b0);
        cycle(1'b1, 32'hD2, 32'h302, 1'b0, 1'b0);
        idle();
        chk("prereset_count", 64'(count), 64'd2);
        #1 rstN = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_head", {out_npc, out_ir}, 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd1);
        idle();
        cycle(1'b1, 32'hC1, 32'h401, 1'b0, 1'b0);
        rstN = 1'b1;
        idle();
        chk("postreset_count", 64'(count), 64'd1);
        chk("postreset_ir", 64'(out_ir), 64'hC1);
        chk("postreset_npc", 64'(out_npc), 64'h401);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        idle();
        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
